// File: rtl/conv3_pkg.sv
// Shared constants and types for the streaming 3x3 window generator.
package conv3_pkg;

   localparam int KERNEL_SIZE = 3;
   localparam int PIXEL_WIDTH = 5;

   // FILL: the two line buffers are still being primed (rows 0 and 1).
   // STREAM: every accepted pixel at col >= 2 completes a window.
   typedef enum logic {
      FILL   = 1'b0,
      STREAM = 1'b1
   } win_state_e;

   typedef logic signed [PIXEL_WIDTH-1:0] pixel_t;

endpackage

// File: rtl/conv3_line_buffer.sv
// One image row of pixel storage with single-port read-before-write access.
// The read is combinational so the entry being overwritten this cycle is
// still visible to the caller; contents are never reset.
module conv3_line_buffer #(
   parameter int DATA_WIDTH = 5,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                         i_clk,
   input  logic                         i_we,
   input  logic [ADDR_WIDTH-1:0]        i_addr,
   input  logic signed [DATA_WIDTH-1:0] i_wdata,
   output logic signed [DATA_WIDTH-1:0] o_rdata
);

   logic signed [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   assign o_rdata = mem[i_addr];

   // Overwrite the addressed entry when a pixel is accepted.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem[i_addr] <= i_wdata;
      end
   end

endmodule

// File: rtl/conv3_window_gen.sv
// Streaming 3x3 window generator. Accepts one signed pixel per handshake in
// raster order, keeps the two previous rows in line buffers and emits one
// complete neighbourhood per accepted pixel once the window lies fully
// inside the image. Output is a single register with pass-through
// backpressure; pixels pass through bit-exact.
module conv3_window_gen
   import conv3_pkg::*;
#(
   parameter int DATA_WIDTH = 5,
   parameter int IMG_WIDTH  = 32,
   parameter int IMG_HEIGHT = 32
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_valid,
   input  logic signed [DATA_WIDTH-1:0] i_pixel,
   output logic                         o_ready,
   output logic                         o_valid,
   output logic signed [DATA_WIDTH-1:0] o_window [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1],
   output logic                         o_last,
   input  logic                         i_ready
);

   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT);
   localparam logic [COL_W-1:0] LAST_COL      = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] LAST_ROW      = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [COL_W-1:0] FIRST_WIN_COL = COL_W'(KERNEL_SIZE - 1);
   localparam logic [ROW_W-1:0] LAST_FILL_ROW = ROW_W'(KERNEL_SIZE - 2);

   logic [COL_W-1:0] col_q;
   logic [ROW_W-1:0] row_q;
   win_state_e       state_q;
   win_state_e       state_d;

   logic acc;
   logic at_last_col;
   logic at_last_row;
   logic frame_end;
   logic emit;

   logic signed [DATA_WIDTH-1:0] lb0_rdata;
   logic signed [DATA_WIDTH-1:0] lb1_rdata;

   // win_p0 is the running column shift register; win_d is its next value,
   // which is also what an emitting pixel publishes on o_window.
   logic signed [DATA_WIDTH-1:0] win_p0 [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1];
   logic signed [DATA_WIDTH-1:0] win_d  [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1];

   assign o_ready     = ~o_valid | i_ready;
   assign acc         = i_valid & o_ready;
   assign at_last_col = (col_q == LAST_COL);
   assign at_last_row = (row_q == LAST_ROW);
   assign frame_end   = at_last_col & at_last_row;
   assign emit        = acc & (state_q == STREAM) & (col_q >= FIRST_WIN_COL);

   // Raster position of the next pixel; wraps at row and frame ends.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         col_q <= '0;
         row_q <= '0;
      end else if (acc) begin
         if (at_last_col) begin
            col_q <= '0;
            row_q <= at_last_row ? '0 : row_q + 1'b1;
         end else begin
            col_q <= col_q + 1'b1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= FILL;
      end else begin
         state_q <= state_d;
      end
   end

   // Leave FILL after row 1 completes; return to FILL after the frame's last pixel.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL: begin
            if (acc && at_last_col && (row_q == LAST_FILL_ROW)) begin
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (acc && frame_end) begin
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // Shift the window left one column and insert the new column (oldest row on top).
   always_comb begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
         for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
            win_d[r][c] = win_p0[r][c+1];
         end
      end
      win_d[0][KERNEL_SIZE-1] = lb0_rdata;
      win_d[1][KERNEL_SIZE-1] = lb1_rdata;
      win_d[2][KERNEL_SIZE-1] = i_pixel;
   end

   // Column shift register advances on every accepted pixel; stale contents
   // after reset are flushed before col reaches 2 in a streaming row.
   always_ff @(posedge i_clk) begin
      if (acc) begin
         win_p0 <= win_d;
      end
   end

   // Output register: load on emit, drop valid once the held window is taken.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid <= 1'b0;
         o_last  <= 1'b0;
         for (int r = 0; r < KERNEL_SIZE; r++) begin
            for (int c = 0; c < KERNEL_SIZE; c++) begin
               o_window[r][c] <= '0;
            end
         end
      end else if (emit) begin
         o_valid  <= 1'b1;
         o_last   <= frame_end;
         o_window <= win_d;
      end else if (i_ready) begin
         o_valid <= 1'b0;
         o_last  <= 1'b0;
      end
   end

   // LB0 holds row r-2 and is refilled from LB1's outgoing entry.
   conv3_line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_WIDTH),
      .ADDR_WIDTH (COL_W)
   ) u_lb0 (
      .i_clk   (i_clk),
      .i_we    (acc),
      .i_addr  (col_q),
      .i_wdata (lb1_rdata),
      .o_rdata (lb0_rdata)
   );

   // LB1 holds row r-1 and is refilled with the incoming pixel.
   conv3_line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_WIDTH),
      .ADDR_WIDTH (COL_W)
   ) u_lb1 (
      .i_clk   (i_clk),
      .i_we    (acc),
      .i_addr  (col_q),
      .i_wdata (i_pixel),
      .o_rdata (lb1_rdata)
   );

endmodule

// File: tb/tb_conv3_window_gen.sv
// Bench for conv3_window_gen on a 4x4 image: directed stimulus with a
// frame-image reference model feeding a scoreboard of expected windows.
module tb_conv3_window_gen;
   import conv3_pkg::*;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int DW = 5;

   logic   clk     = 1'b0;
   logic   rst_n   = 1'b0;
   logic   i_valid = 1'b0;
   logic   i_ready = 1'b1;
   pixel_t i_pixel = '0;
   logic   o_ready;
   logic   o_valid;
   logic   o_last;
   logic signed [DW-1:0] o_window [0:2][0:2];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct packed {
      logic [44:0] win;
      logic        last;
      logic [31:0] acc_cyc;
   } exp_t;

   exp_t q[$];

   int img [0:H-1][0:W-1];
   int m_row = 0;
   int m_col = 0;

   int   seen      = 0;
   int   seen_base = 0;
   logic holding   = 1'b0;
   logic [44:0] hold_win  = '0;
   logic        hold_last = 1'b0;

   logic bp_arm = 1'b0;
   int   bp_cnt = 0;

   logic [44:0] win_flat;

   conv3_window_gen #(
      .DATA_WIDTH (DW),
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H)
   ) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_valid  (i_valid),
      .i_pixel  (i_pixel),
      .o_ready  (o_ready),
      .o_valid  (o_valid),
      .o_window (o_window),
      .o_last   (o_last),
      .i_ready  (i_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      win_flat = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            win_flat[(r*3+c)*5 +: 5] = o_window[r][c];
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Reference model: store the pixel in a full frame image, predict a window when complete.
   task automatic model_accept(input int p, input int acc_cyc);
      exp_t e;
      img[m_row][m_col] = p;
      if (m_row >= 2 && m_col >= 2) begin
         e.win = '0;
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               e.win[(r*3+c)*5 +: 5] = 5'(img[m_row-2+r][m_col-2+c]);
            end
         end
         e.last    = (m_row == H-1) && (m_col == W-1);
         e.acc_cyc = acc_cyc;
         q.push_back(e);
      end
      if (m_col == W-1) begin
         m_col = 0;
         m_row = (m_row == H-1) ? 0 : m_row + 1;
      end else begin
         m_col++;
      end
   endtask

   // Advance one clock; inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (bp_arm && o_valid) begin
         i_ready = 1'b0;
         bp_cnt  = 3;
         bp_arm  = 1'b0;
      end else if (bp_cnt > 0) begin
         bp_cnt--;
         if (bp_cnt == 0) i_ready = 1'b1;
      end
      #1;
   endtask

   task automatic send(input int p);
      int guard;
      guard   = 0;
      i_valid = 1'b1;
      i_pixel = pixel_t'(p);
      while (!o_ready && guard < 20) begin
         tick();
         guard++;
      end
      check("accept_wait", 64'(o_ready), 64'd1);
      if (o_ready) model_accept(p, cyc + 1);
      tick();
      i_valid = 1'b0;
   endtask

   task automatic drain(input string tag, input int n_exp);
      int guard;
      guard   = 0;
      i_valid = 1'b0;
      while ((q.size() != 0 || o_valid) && guard < 50) begin
         tick();
         guard++;
      end
      check({tag, "_queue_empty"}, 64'(q.size()), 64'd0);
      check({tag, "_count"}, 64'(seen - seen_base), 64'(n_exp));
      seen_base = seen;
   endtask

   // Output monitor: compares each new window against the scoreboard head.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            holding = 1'b0;
         end else if (o_valid) begin
            if (holding) begin
               check("stall_window", 64'(win_flat), 64'(hold_win));
               check("stall_last", 64'(o_last), 64'(hold_last));
            end else if (q.size() == 0) begin
               check("unexpected_window", 64'(o_valid), 64'd0);
            end else begin
               check("window", 64'(win_flat), 64'(q[0].win));
               check("last", 64'(o_last), 64'(q[0].last));
               check("latency", 64'(cyc), 64'(q[0].acc_cyc));
            end
            if (i_ready) begin
               if (q.size() != 0) void'(q.pop_front());
               seen++;
               holding = 1'b0;
            end else begin
               check("stall_ready", 64'(o_ready), 64'd0);
               holding   = 1'b1;
               hold_win  = win_flat;
               hold_last = o_last;
            end
         end else begin
            holding = 1'b0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=time limit expected=finish");
      $fatal(1);
   end

   initial begin
      // Power-on reset
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_last", 64'(o_last), 64'd0);
      check("rst_window", 64'(win_flat), 64'd0);
      rst_n = 1'b1;
      #1;
      check("rst_ready", 64'(o_ready), 64'd1);

      // Basic frame
      for (int i = 0; i < 16; i++) send(i);
      drain("basic", 4);

      // Backpressure on the first window
      bp_arm = 1'b1;
      for (int i = 0; i < 16; i++) send(i);
      drain("backpressure", 4);
      check("bp_triggered", 64'(bp_arm), 64'd0);

      // Input bubbles
      for (int i = 0; i < 16; i++) begin
         send(i);
         tick();
      end
      drain("bubbles", 4);

      // Signed extremes
      for (int i = 0; i < 16; i++) send((i % 2 == 0) ? -16 : 15);
      drain("signed", 4);

      // Back-to-back frames
      for (int i = 0; i < 32; i++) send(i);
      drain("b2b", 8);

      // Reset mid-frame
      for (int i = 0; i < 10; i++) send(i);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 64'(o_valid), 64'd0);
      check("midrst_last", 64'(o_last), 64'd0);
      check("midrst_window", 64'(win_flat), 64'd0);
      q.delete();
      m_row = 0;
      m_col = 0;
      tick();
      tick();
      check("midrst_hold_valid", 64'(o_valid), 64'd0);
      rst_n = 1'b1;
      #1;
      check("midrst_ready", 64'(o_ready), 64'd1);
      seen_base = seen;
      for (int i = 0; i < 16; i++) send(i);
      drain("midrst", 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conv3_window_gen.md
# conv3_window_gen

Streaming 3x3 window generator that produces the `i_data` window consumed by the 3x3 convolution datapath. It accepts one signed pixel per handshake in raster order and buffers the two previous image rows in line buffers. It emits one complete 3x3 neighbourhood per accepted pixel once the window lies fully inside the image (valid-only convolution, no padding). It sits between the pixel source and the convolution pipeline.

## Interface
- `DATA_WIDTH`, 5, pixel width, signed two's complement.
- `IMG_WIDTH`, 32, pixels per row; must be ≥ 3.
- `IMG_HEIGHT`, 32, rows per frame; must be ≥ 3.
- `i_clk`  input  1  clock; all logic on rising edge.
- `i_rst_n`  input  1  reset; asynchronous, active-low.
- `i_valid`  input  1  pixel on `i_pixel` is valid.
- `i_pixel`  input  signed DATA_WIDTH  pixel, raster order (row-major, left to right).
- `o_ready`  output  1  block can accept a pixel this cycle.
- `o_valid`  output  1  `o_window` holds a valid window.
- `o_window`  output  signed DATA_WIDTH [0:2][0:2]  window; `[r][c]` is row r, column c; `[0][0]` is top-left; `[2][2]` is the newest pixel.
- `o_last`  output  1  qualifies `o_valid`; marks the last window of a frame.
- `i_ready`  input  1  downstream accepts the window this cycle.

## Operation
- Pixel accept: `acc = i_valid & o_ready`. Window accept: `o_valid & i_ready`.
- `o_ready = ~o_valid | i_ready`. This is a single output register with pass-through backpressure.
- Counters:
  - `col`: 0..IMG_WIDTH-1.
  - `row`: 0..IMG_HEIGHT-1.
  - Both advance only on `acc`.
  - `col` wraps to 0 and increments `row`.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0 and the next frame starts immediately.
- Line buffers:
  - LB1 holds row r-1. LB0 holds row r-2.
  - On `acc` at column c, read LB0[c] and LB1[c]. Write LB0[c] ← LB1[c] and LB1[c] ← `i_pixel`.
- Window shift:
  - On `acc`, the shift register shifts left one column: `[*][0]←[*][1]`, `[*][1]←[*][2]`.
  - The new column is `[0][2]`=LB0[c], `[1][2]`=LB1[c], `[2][2]`=`i_pixel`.
- State machine (`row` is the pre-accept value):
  - `FILL`: row < 2. No windows emitted.
  - `STREAM`: row ≥ 2.
  - FILL→STREAM when `acc` occurs at col=IMG_WIDTH-1, row=1.
  - STREAM→FILL when `acc` occurs at the last pixel of the frame.
- Emission: `acc` in STREAM with col ≥ 2 sets `o_valid` on the next edge, with the updated window. `o_last` is set if that pixel is the frame's last.
- `acc` that emits nothing (FILL, or col < 2):
  - Clears `o_valid` only if the current window was accepted that cycle.
  - Otherwise `o_valid` holds.
  - This cannot occur while `o_valid & ~i_ready`, because `o_ready` is 0 then.
- Windows per frame: (IMG_HEIGHT-2)·(IMG_WIDTH-2).
- No arithmetic is performed; pixels pass through bit-exact. The window never straddles rows, because col ≥ 2 guarantees all three columns come from the current row.

## Timing
- Reset values:
  - `o_valid`=0, `o_last`=0, `o_window`=all 0.
  - Counters=0, state=FILL.
  - `o_ready`=1 in the first cycle after reset release.
  - Line-buffer RAM is not reset; FILL overwrites it before any read reaches the output.
- Latency: 1 cycle from pixel accept to `o_valid`/`o_window`.
- Throughput: one pixel per cycle with `i_ready` held high.
- Stall: while `o_valid & ~i_ready`, `o_ready`=0 and `o_window`/`o_last` stay stable. No pixel is lost.
- Simultaneous window accept and emitting `acc`: the new window replaces the old on the same edge, with no bubble.
- Reset mid-frame: outputs return to their reset values immediately (asynchronous). The next accepted pixel is treated as (row 0, col 0).
- Frame boundary: back-to-back frames without idle cycles. The first window of frame N+1 follows its pixel (2, 2).

## Structure
- Package `conv3_pkg`:
  - `localparam KERNEL_SIZE = 3`.
  - State enum `win_state_e {FILL, STREAM}`.
  - Typedef for the signed pixel width.
- Sub-module `conv3_line_buffer`:
  - IMG_WIDTH-deep, DATA_WIDTH-wide, single-port read-before-write at address `col`.
  - Instantiated twice (LB0, LB1).
- Counters, FSM, window shift register and output register live in the top module.

## Test plan
- **Basic frame.** IMG_WIDTH=IMG_HEIGHT=4, pixels 0..15 back-to-back, `i_ready`=1.
  - Exactly 4 windows, one cycle after pixels 10, 11, 14, 15.
  - First window rows: {0,1,2}, {4,5,6}, {8,9,10}.
  - Last window rows: {5,6,7}, {9,10,11}, {13,14,15}; `o_last`=1 only on this window.
- **Backpressure.** As in Basic frame, but `i_ready`=0 for 3 cycles when the first window appears.
  - `o_ready`=0 and the window is held stable.
  - After release, the remaining 3 windows arrive in order, with none lost or duplicated.
- **Input bubbles.** `i_valid` toggles 1/0 on alternate cycles.
  - Same 4 windows, each 1 cycle after its pixel accept.
  - `o_valid` holds until accepted.
- **Signed extremes.** Pixels alternate -16 and 15.
  - Window values match bit-exact, including -16 (5'b10000).
- **Back-to-back frames.** Two frames: 0..15 then 16..31.
  - Second frame's first window is rows {16,17,18}, {20,21,22}, {24,25,26}.
  - No window straddles the two frames.
- **Reset mid-frame.** Assert `i_rst_n`=0 after pixel 9, then send 0..15.
  - During reset, `o_valid`=0 and `o_window`=0.
  - Output is identical to Basic frame.
